// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and widths for the bus select arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int REGION_W = 2;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/sel_decoder_2to4.sv
// rtl/sel_decoder_2to4.sv - enable-gated active-low one-hot chip-select decode
module sel_decoder_2to4
    import bus_arb_pkg::*;
(
    input  logic                en,
    input  logic [REGION_W-1:0] region,
    output logic [3:0]          cs_n
);

    always_comb begin
        cs_n = 4'b1111;
        if (en) begin
            cs_n[region] = 1'b0;
        end
    end

endmodule

// File: rtl/bus_select_arbiter.sv
// rtl/bus_select_arbiter.sv - two-requester bus arbiter and chip-select sequencer
// Optional: BUS_ARB_FIXED_PRIORITY_EN makes requester A win every tie.
module bus_select_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              rw_a,
    input  logic              rw_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rw,
    output logic [3:0]        cs_n,
    output logic              busy
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_t            state;
    state_t            state_nxt;
    logic              own_b;
    logic              pick_b;
    logic              any_req;
    logic              strobe_en;
    logic [WAIT_W-1:0] wait_cnt;

    assign any_req = req_a | req_b;

    // own_b doubles as the last-grant pointer: it is rewritten on every entry to SETUP
`ifdef BUS_ARB_FIXED_PRIORITY_EN
    assign pick_b = req_b & ~req_a;
`else
    assign pick_b = req_b & (~req_a | ~own_b);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: if (wait_cnt == '0) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_b    <= 1'b1;
            bus_addr <= '0;
            bus_rw   <= 1'b1;
            wait_cnt <= '0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                own_b    <= pick_b;
                bus_addr <= pick_b ? addr_b : addr_a;
                bus_rw   <= pick_b ? rw_b : rw_a;
            end
            if (state == ST_SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_STROBE && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        gnt_a     = (state != ST_IDLE) & ~own_b;
        gnt_b     = (state != ST_IDLE) & own_b;
        ack_a     = (state == ST_DONE) & ~own_b;
        ack_b     = (state == ST_DONE) & own_b;
        strobe_en = (state == ST_STROBE);
    end

    sel_decoder_2to4 u_sel_decoder (
        .en     (strobe_en),
        .region (bus_addr[ADDR_W-1 -: REGION_W]),
        .cs_n   (cs_n)
    );

endmodule

// File: tb/tb_bus_select_arbiter.sv
// tb/tb_bus_select_arbiter.sv - directed vector bench for bus_select_arbiter
module tb_bus_select_arbiter;

    typedef struct {
        logic        rst_n;
        logic        ra;
        logic        rb;
        logic [15:0] aa;
        logic [15:0] ab;
        logic        rwa;
        logic        rwb;
        logic [25:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, req_a, req_b, rw_a, rw_b;
    logic [15:0] addr_a, addr_b;
    logic        ack_a, ack_b, gnt_a, gnt_b, bus_rw, busy;
    logic [15:0] bus_addr;
    logic [3:0]  cs_n;

    logic        rst0_n, req_a0, req_b0, rw_a0, rw_b0;
    logic [15:0] addr_a0, addr_b0;
    logic        ack_a0, ack_b0, gnt_a0, gnt_b0, bus_rw0, busy0;
    logic [15:0] bus_addr0;
    logic [3:0]  cs_n0;

    int pass_cnt = 0;
    int total_cnt = 0;

    vec_t vecs[27];

    wire [25:0] obs  = {gnt_a, gnt_b, ack_a, ack_b, cs_n, busy, bus_addr, bus_rw};
    wire [25:0] obs0 = {gnt_a0, gnt_b0, ack_a0, ack_b0, cs_n0, busy0, bus_addr0, bus_rw0};

    always #5 clk = ~clk;

    bus_select_arbiter #(.ADDR_W(16), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .addr_a(addr_a), .addr_b(addr_b), .rw_a(rw_a), .rw_b(rw_b),
        .ack_a(ack_a), .ack_b(ack_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .cs_n(cs_n), .busy(busy)
    );

    bus_select_arbiter #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .req_a(req_a0), .req_b(req_b0),
        .addr_a(addr_a0), .addr_b(addr_b0), .rw_a(rw_a0), .rw_b(rw_b0),
        .ack_a(ack_a0), .ack_b(ack_b0), .gnt_a(gnt_a0), .gnt_b(gnt_b0),
        .bus_addr(bus_addr0), .bus_rw(bus_rw0), .cs_n(cs_n0), .busy(busy0)
    );

    function automatic vec_t mk(logic r, logic ra, logic rb, logic [15:0] aa, logic [15:0] ab,
                                logic rwa, logic rwb, logic ga, logic gb, logic ka, logic kb,
                                logic [3:0] cs, logic bz, logic [15:0] ba, logic brw);
        vec_t v;
        v.rst_n = r; v.ra = ra; v.rb = rb; v.aa = aa; v.ab = ab; v.rwa = rwa; v.rwb = rwb;
        v.exp = {ga, gb, ka, kb, cs, bz, ba, brw};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] order[5];
        logic [1:0] exp_who;
        int         n_grants;
        int         overlap;
        int         acks;

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; addr_a = '0; addr_b = '0; rw_a = 1'b1; rw_b = 1'b1;
        rst0_n = 1'b0; req_a0 = 1'b0; req_b0 = 1'b0; addr_a0 = '0; addr_b0 = '0; rw_a0 = 1'b1; rw_b0 = 1'b1;

        //            rst ra rb aa        ab        rwa rwb ga gb ka kb cs     bz ba        brw
        vecs[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1,  0, 0, 0, 0, 4'hF, 0, 16'h0000, 1);
        vecs[1]  = mk(1, 1, 0, 16'h8000, 16'h0000, 1, 1,  1, 0, 0, 0, 4'hF, 1, 16'h8000, 1);
        vecs[2]  = mk(1, 1, 0, 16'h8000, 16'h0000, 1, 1,  1, 0, 0, 0, 4'hB, 1, 16'h8000, 1);
        vecs[3]  = mk(1, 1, 0, 16'h8000, 16'h0000, 1, 1,  1, 0, 0, 0, 4'hB, 1, 16'h8000, 1);
        vecs[4]  = mk(1, 1, 0, 16'h8000, 16'h0000, 1, 1,  1, 0, 1, 0, 4'hF, 1, 16'h8000, 1);
        vecs[5]  = mk(1, 0, 0, 16'h8000, 16'h0000, 1, 1,  0, 0, 0, 0, 4'hF, 0, 16'h8000, 1);
        vecs[6]  = mk(1, 1, 0, 16'h4000, 16'h0000, 0, 1,  1, 0, 0, 0, 4'hF, 1, 16'h4000, 0);
        vecs[7]  = mk(1, 1, 0, 16'h0000, 16'h0000, 0, 1,  1, 0, 0, 0, 4'hD, 1, 16'h4000, 0);
        vecs[8]  = mk(1, 1, 0, 16'h0000, 16'h0000, 0, 1,  1, 0, 0, 0, 4'hD, 1, 16'h4000, 0);
        vecs[9]  = mk(1, 1, 0, 16'h0000, 16'h0000, 0, 1,  1, 0, 1, 0, 4'hF, 1, 16'h4000, 0);
        vecs[10] = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1,  0, 0, 0, 0, 4'hF, 0, 16'h4000, 0);
        vecs[11] = mk(0, 1, 1, 16'h1000, 16'hF000, 1, 0,  0, 0, 0, 0, 4'hF, 0, 16'h0000, 1);
        vecs[12] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 0, 0, 4'hF, 1, 16'h1000, 1);
        vecs[13] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 0, 0, 4'hE, 1, 16'h1000, 1);
        vecs[14] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 0, 0, 4'hE, 1, 16'h1000, 1);
        vecs[15] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 1, 0, 4'hF, 1, 16'h1000, 1);
        vecs[16] = mk(1, 0, 1, 16'h1000, 16'hF000, 1, 0,  0, 0, 0, 0, 4'hF, 0, 16'h1000, 1);
        vecs[17] = mk(1, 0, 1, 16'h1000, 16'hF000, 1, 0,  0, 1, 0, 0, 4'hF, 1, 16'hF000, 0);
        vecs[18] = mk(1, 0, 1, 16'h1000, 16'hF000, 1, 0,  0, 1, 0, 0, 4'h7, 1, 16'hF000, 0);
        vecs[19] = mk(1, 0, 1, 16'h1000, 16'hF000, 1, 0,  0, 1, 0, 0, 4'h7, 1, 16'hF000, 0);
        vecs[20] = mk(1, 0, 1, 16'h1000, 16'hF000, 1, 0,  0, 1, 0, 1, 4'hF, 1, 16'hF000, 0);
        vecs[21] = mk(1, 0, 0, 16'h1000, 16'hF000, 1, 0,  0, 0, 0, 0, 4'hF, 0, 16'hF000, 0);
        vecs[22] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 0, 0, 4'hF, 1, 16'h1000, 1);
        vecs[23] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 0, 0, 4'hE, 1, 16'h1000, 1);
        vecs[24] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 0, 0, 4'hE, 1, 16'h1000, 1);
        vecs[25] = mk(1, 1, 1, 16'h1000, 16'hF000, 1, 0,  1, 0, 1, 0, 4'hF, 1, 16'h1000, 1);
        vecs[26] = mk(1, 0, 0, 16'h1000, 16'hF000, 1, 0,  0, 0, 0, 0, 4'hF, 0, 16'h1000, 1);

        for (int i = 0; i < 27; i++) begin
            rst_n = vecs[i].rst_n; req_a = vecs[i].ra; req_b = vecs[i].rb;
            addr_a = vecs[i].aa; addr_b = vecs[i].ab; rw_a = vecs[i].rwa; rw_b = vecs[i].rwb;
            step();
            chk($sformatf("vec%0d", i), {6'd0, obs}, {6'd0, vecs[i].exp});
        end

        // reset abort in the second strobe cycle, then a fresh access
        req_a = 1'b1; addr_a = 16'h8000; rw_a = 1'b1; req_b = 1'b0;
        step(); step(); step();
        chk("abort_in_strobe2", {31'd0, cs_n == 4'hB}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("abort_reset_state", {6'd0, obs}, {6'd0, 4'b0000, 4'hF, 1'b0, 16'h0000, 1'b1});
        rst_n = 1'b1;
        step();
        chk("abort_fresh_setup", {6'd0, obs}, {6'd0, 4'b1000, 4'hF, 1'b1, 16'h8000, 1'b1});
        acks = 0;
        for (int c = 0; c < 10 && acks == 0; c++) begin
            step();
            if (ack_a) acks++;
        end
        chk("abort_fresh_ack", acks, 1);
        req_a = 1'b0;
        step(); step();

        // continuous contention from reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req_a = 1'b1; req_b = 1'b1; addr_a = 16'h2000; addr_b = 16'hA000;
        n_grants = 0; overlap = 0;
        for (int c = 0; c < 40 && n_grants < 5; c++) begin
            step();
            if (gnt_a && gnt_b) overlap++;
            if ($countones(~cs_n) > 1) overlap++;
            if (ack_a || ack_b) begin
                order[n_grants] = {ack_a, ack_b};
                n_grants++;
            end
        end
        chk("contend_grants_seen", n_grants, 5);
        for (int g = 0; g < 5; g++) begin
`ifdef BUS_ARB_FIXED_PRIORITY_EN
            exp_who = 2'b10;
`else
            exp_who = (g % 2 == 0) ? 2'b10 : 2'b01;
`endif
            if (g < n_grants) chk($sformatf("contend_grant%0d", g), {30'd0, order[g]}, {30'd0, exp_who});
        end
        chk("contend_no_overlap", overlap, 0);
        req_a = 1'b0; req_b = 1'b0;
        step(); step(); step(); step(); step();

        // zero wait states, requester B
        chk("ws0_reset", {6'd0, obs0}, {6'd0, 4'b0000, 4'hF, 1'b0, 16'h0000, 1'b1});
        rst0_n = 1'b1; req_b0 = 1'b1; addr_b0 = 16'hC123; rw_b0 = 1'b0;
        step();
        chk("ws0_setup",  {6'd0, obs0}, {6'd0, 4'b0100, 4'hF, 1'b1, 16'hC123, 1'b0});
        step();
        chk("ws0_strobe", {6'd0, obs0}, {6'd0, 4'b0100, 4'h7, 1'b1, 16'hC123, 1'b0});
        step();
        chk("ws0_done",   {6'd0, obs0}, {6'd0, 4'b0101, 4'hF, 1'b1, 16'hC123, 1'b0});
        req_b0 = 1'b0;
        step();
        chk("ws0_idle",   {6'd0, obs0}, {6'd0, 4'b0000, 4'hF, 1'b0, 16'hC123, 1'b0});
        req_b0 = 1'b1; rw_b0 = 1'b1;
        step();
        chk("ws0_rw_read", {6'd0, obs0}, {6'd0, 4'b0100, 4'hF, 1'b1, 16'hC123, 1'b1});
        req_b0 = 1'b0;
        step(); step(); step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
